// File: rtl/i2c_slave_rf.sv
// I2C target (7-bit address) with a byte-wide register file, pointer write, burst write/read.
// Optional input glitch filter enabled by defining I2C_SLV_GLITCH_FILT_EN.
module i2c_slave_rf #(
  parameter logic [6:0] SLV_ADDR = 7'h2d,
  parameter int         REG_AW   = 4,
  parameter logic [7:0] RST_VAL  = 8'h00
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              scl,
  inout  wire               sda,
  output logic              wr_vld,
  output logic [REG_AW-1:0] wr_addr,
  output logic [7:0]        wr_data,
  input  logic [REG_AW-1:0] rf_rd_addr,
  output logic [7:0]        rf_rd_data,
  output logic              busy
);

  localparam int DEPTH = 1 << REG_AW;

  typedef enum logic [3:0] {
    IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK
  } state_t;

  logic [1:0] scl_sync_q, sda_sync_q;
  logic       scl_f, sda_f;
  logic       scl_prev_q, sda_prev_q;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      scl_sync_q <= 2'b11;
      sda_sync_q <= 2'b11;
    end else begin
      scl_sync_q <= {scl_sync_q[0], scl};
      sda_sync_q <= {sda_sync_q[0], sda};
    end
  end

`ifdef I2C_SLV_GLITCH_FILT_EN
  logic       scl_flt_q, sda_flt_q;
  logic [1:0] scl_cnt_q, sda_cnt_q;

  // A new level is accepted only after it has persisted for three clk cycles
  always_ff @(posedge clk) begin
    if (!rstn) begin
      scl_flt_q <= 1'b1;
      sda_flt_q <= 1'b1;
      scl_cnt_q <= 2'd0;
      sda_cnt_q <= 2'd0;
    end else begin
      if (scl_sync_q[1] != scl_flt_q) begin
        if (scl_cnt_q == 2'd2) begin
          scl_flt_q <= scl_sync_q[1];
          scl_cnt_q <= 2'd0;
        end else begin
          scl_cnt_q <= scl_cnt_q + 2'd1;
        end
      end else begin
        scl_cnt_q <= 2'd0;
      end
      if (sda_sync_q[1] != sda_flt_q) begin
        if (sda_cnt_q == 2'd2) begin
          sda_flt_q <= sda_sync_q[1];
          sda_cnt_q <= 2'd0;
        end else begin
          sda_cnt_q <= sda_cnt_q + 2'd1;
        end
      end else begin
        sda_cnt_q <= 2'd0;
      end
    end
  end

  assign scl_f = scl_flt_q;
  assign sda_f = sda_flt_q;
`else
  assign scl_f = scl_sync_q[1];
  assign sda_f = sda_sync_q[1];
`endif

  always_ff @(posedge clk) begin
    if (!rstn) begin
      scl_prev_q <= 1'b1;
      sda_prev_q <= 1'b1;
    end else begin
      scl_prev_q <= scl_f;
      sda_prev_q <= sda_f;
    end
  end

  logic scl_rise, scl_fall, start_det, stop_det;
  assign scl_rise  = scl_f & ~scl_prev_q;
  assign scl_fall  = ~scl_f & scl_prev_q;
  assign start_det = scl_f & scl_prev_q & sda_prev_q & ~sda_f;
  assign stop_det  = scl_f & scl_prev_q & ~sda_prev_q & sda_f;

  state_t            state_q, state_d;
  logic [3:0]        bit_cnt_q, bit_cnt_d;
  logic [7:0]        shr_q, shr_d;
  logic [7:0]        tx_q, tx_d;
  logic              rw_q, rw_d;
  logic [REG_AW-1:0] ptr_q, ptr_d, ptr_inc;
  logic              oe_q, oe_d;
  logic              busy_q, busy_d;
  logic              wr_vld_q, wr_vld_d;
  logic [REG_AW-1:0] wr_addr_q, wr_addr_d;
  logic [7:0]        wr_data_q, wr_data_d;
  logic [7:0]        rx_byte;
  logic [7:0]        rf_q [DEPTH];

  assign rx_byte = {shr_q[6:0], sda_f};
  assign ptr_inc = ptr_q + 1'b1;

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shr_d     = shr_q;
    tx_d      = tx_q;
    rw_d      = rw_q;
    ptr_d     = ptr_q;
    oe_d      = oe_q;
    busy_d    = busy_q;
    wr_vld_d  = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    if (start_det) begin
      state_d   = ADDR;
      bit_cnt_d = 4'd0;
      oe_d      = 1'b0;
      busy_d    = 1'b0;
    end else if (stop_det) begin
      state_d = IDLE;
      oe_d    = 1'b0;
      busy_d  = 1'b0;
    end else begin
      case (state_q)
        IDLE: ;
        ADDR, PTR, WDATA: begin
          // Falling edge ending a preceding ACK hands SDA back to the master
          if (scl_fall) oe_d = 1'b0;
          if (scl_rise) begin
            shr_d     = rx_byte;
            bit_cnt_d = bit_cnt_q + 4'd1;
            if (bit_cnt_q == 4'd7) begin
              bit_cnt_d = 4'd0;
              if (state_q == ADDR) begin
                if (rx_byte[7:1] == SLV_ADDR) begin
                  state_d = ADDR_ACK;
                  rw_d    = rx_byte[0];
                  busy_d  = 1'b1;
                end else begin
                  state_d = IDLE;
                end
              end else if (state_q == PTR) begin
                ptr_d   = rx_byte[REG_AW-1:0];
                state_d = PTR_ACK;
              end else begin
                wr_vld_d  = 1'b1;
                wr_addr_d = ptr_q;
                wr_data_d = rx_byte;
                ptr_d     = ptr_inc;
                state_d   = WDATA_ACK;
              end
            end
          end
        end
        ADDR_ACK, PTR_ACK, WDATA_ACK: begin
          if (scl_fall) oe_d = 1'b1;
          if (scl_rise) begin
            bit_cnt_d = 4'd0;
            if (state_q == ADDR_ACK && rw_q) begin
              state_d = RDATA;
              tx_d    = rf_q[ptr_q];
            end else if (state_q == ADDR_ACK) begin
              state_d = PTR;
            end else begin
              state_d = WDATA;
            end
          end
        end
        RDATA: begin
          // bit_cnt counts rising edges, so zero means the MSB is not yet on the bus
          if (scl_fall) begin
            if (bit_cnt_q == 4'd0) begin
              oe_d = ~tx_q[7];
            end else begin
              tx_d = {tx_q[6:0], 1'b0};
              oe_d = ~tx_q[6];
            end
          end
          if (scl_rise) begin
            bit_cnt_d = bit_cnt_q + 4'd1;
            if (bit_cnt_q == 4'd7) state_d = RDATA_ACK;
          end
        end
        RDATA_ACK: begin
          if (scl_fall) oe_d = 1'b0;
          if (scl_rise) begin
            ptr_d     = ptr_inc;
            bit_cnt_d = 4'd0;
            if (!sda_f) begin
              state_d = RDATA;
              tx_d    = rf_q[ptr_inc];
            end else begin
              state_d = IDLE;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q   <= IDLE;
      bit_cnt_q <= 4'd0;
      ptr_q     <= '0;
      oe_q      <= 1'b0;
      busy_q    <= 1'b0;
      wr_vld_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      ptr_q     <= ptr_d;
      oe_q      <= oe_d;
      busy_q    <= busy_d;
      wr_vld_q  <= wr_vld_d;
    end
  end

  always_ff @(posedge clk) begin
    shr_q     <= shr_d;
    tx_q      <= tx_d;
    rw_q      <= rw_d;
    wr_addr_q <= wr_addr_d;
    wr_data_q <= wr_data_d;
  end

  // Commit one cycle after the notify so the local port shows the old value during wr_vld
  always_ff @(posedge clk) begin
    if (!rstn) begin
      for (int i = 0; i < DEPTH; i++) rf_q[i] <= RST_VAL;
    end else if (wr_vld_q) begin
      rf_q[wr_addr_q] <= wr_data_q;
    end
  end

  assign sda        = oe_q ? 1'b0 : 1'bz;
  assign wr_vld     = wr_vld_q;
  assign wr_addr    = wr_addr_q;
  assign wr_data    = wr_data_q;
  assign rf_rd_data = rf_q[rf_rd_addr];
  assign busy       = busy_q;

endmodule

// File: doc/i2c_slave_rf.md
# i2c_slave_rf

Parametrised I2C target with an internal register file. It decodes 7-bit addressed transfers on `scl`/`sda` and supports a register-pointer write, multi-byte burst writes and burst reads with pointer auto-increment. It also handles repeated START and STOP in any state, and exposes a write-notify strobe and a local read port to the surrounding system logic. It replaces the fixed-buffer slave as the standard peripheral-side I2C endpoint.

## Interface
- `SLV_ADDR`, `'h2d`: 7-bit target address.
- `REG_AW`, `4`: register-file address width, 1..8. Depth is `2**REG_AW` bytes.
- `RST_VAL`, `8'h00`: reset value of every register.
- `clk` input 1: system clock; must run at ≥16× SCL frequency.
- `rstn` input 1: reset, synchronous, active-low.
- `scl` input 1: I2C clock. Input only; no clock stretching.
- `sda` inout 1: I2C data, open-drain. The block drives only `1'b0` or `1'bz`, never `1'b1`.
- `wr_vld` output 1: one-`clk` pulse per byte committed to the register file.
- `wr_addr` output REG_AW: address of the committed byte; valid with `wr_vld`.
- `wr_data` output 8: committed byte; valid with `wr_vld`.
- `rf_rd_addr` input REG_AW: local read-port address.
- `rf_rd_data` output 8: `rf[rf_rd_addr]`, combinational.
- `busy` output 1: high from the START that addresses this target until the next STOP or START.

## Operation
- **Input sampling.** `scl` and `sda` pass through a 2-flop synchroniser. Edges and START/STOP conditions are detected on the synchronised signals.
  - START: `sda` falls while `scl` is high.
  - STOP: `sda` rises while `scl` is high.
- **FSM states:** IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK.
- **START / STOP override.** START in any state goes to ADDR, clears the bit counter and keeps the pointer. STOP in any state goes to IDLE.
- **ADDR.** Shift 8 bits MSB-first on SCL rising edges.
  - Address match: go to ADDR_ACK.
  - Mismatch: go to IDLE and leave SDA released.
- **ADDR_ACK.** Drive SDA low for the 9th clock.
  - Write (R/W=0): next state is PTR.
  - Read (R/W=1): next state is RDATA; load `rf[ptr]` into the TX shifter.
- **PTR.** Receive 8 bits. `ptr` takes the low REG_AW bits; upper bits are ignored. Then PTR_ACK (ACK), then WDATA.
- **WDATA.** Receive 8 bits.
  - On the 8th SCL rising edge, write `rf[ptr]`, pulse `wr_vld`, then increment `ptr`.
  - Then WDATA_ACK (ACK) and back to WDATA. The burst has no length limit.
- **RDATA.** Drive TX bits MSB-first; each bit changes only after a detected SCL falling edge. Then go to RDATA_ACK and release SDA.
- **RDATA_ACK.** Sample the master's response on the 9th SCL rising edge; `ptr` increments on this edge either way.
  - ACK (0): reload from `rf[ptr]` and return to RDATA.
  - NACK (1): go to IDLE, keep SDA released and wait for STOP or START.
- **Pointer arithmetic.** `ptr` is REG_AW bits and wraps `2**REG_AW-1 → 0`.
- **Simultaneous access.** When `rf_rd_addr == wr_addr` in the `wr_vld` cycle, `rf_rd_data` shows the old value and the new value on the next cycle.

## Timing
- **Reset values:** FSM in IDLE, `ptr=0`, all `rf=RST_VAL`, `wr_vld=0`, `busy=0`, SDA released.
- **Reset mid-transfer:** SDA is released at the first `clk` edge with `rstn=0`.
- **SDA drive window:** SDA drive changes 3 `clk` cycles after the physical SCL falling edge (2 sync + 1 register), and never while SCL is high.
- **ACK window:** ACK is driven from the falling edge after bit 8 to the falling edge after bit 9.
- **Write notify:** `wr_vld` asserts 3 `clk` after the physical 8th SCL rising edge of a data byte.
- **`busy`:** rises the cycle ADDR_ACK is entered on a match, and falls the cycle STOP or START is detected.

## Configuration
- Macro `I2C_SLV_GLITCH_FILT_EN`.
- **Defined:** after the synchroniser, each of `scl`/`sda` updates only after its input has been stable for 3 consecutive `clk` cycles. This adds 3 cycles to every latency above and rejects pulses shorter than 3 `clk`.
- **Undefined:** no filter; synchroniser only.

## Test plan
- **Pointer write + burst write:** write to `0x2d`, ptr `0x03`, data `0xA5 0x5A` → ACK on all 4 bytes; `wr_vld` pulses with (3,`0xA5`) then (4,`0x5A`); `rf_rd_addr=4` gives `0x5A`.
- **Burst read via repeated START:** write ptr `0x0F`, repeated START, read ×2 with ACK then NACK → bytes `rf[15]`, `rf[0]` (wrap); SDA released after the NACK; `busy` falls on STOP.
- **Address mismatch:** address `0x2c` write → 9th bit is NACK (SDA stays high), no `wr_vld`, `busy=0`.
- **Reset default:** after reset, read 3 bytes from ptr 0 → `RST_VAL` ×3.
- **Mid-transfer reset:** assert `rstn=0` during an RDATA bit that is driving 0 → SDA is `z` next `clk`; after release, the next transfer works normally.
- **Filter (macro defined):** a 2-`clk` SDA low glitch while SCL is high → no START detected, FSM remains IDLE.
